// File: rtl/peripheral_mpram_wb_burst_master.sv
// Wishbone B3 linear burst master: turns a command plus a write-data stream into
// incrementing bursts and returns read beats as a valid-only stream.
module peripheral_mpram_wb_burst_master #(
  parameter  int DW     = 32,
  parameter  int AW     = 8,
  parameter  int MAXLEN = 16,
  localparam int SW     = DW / 8,
  localparam int LW     = $clog2(MAXLEN) + 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [SW-1:0] cmd_sel_i,
  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  input  logic [DW-1:0] wdat_i,
  output logic          rdat_valid_o,
  output logic [DW-1:0] rdat_o,
  output logic          rdat_last_o,
  output logic          done_o,
  output logic          done_err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [DW-1:0] wb_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [AW-1:0] r_adr;
  logic          r_we;
  logic [SW-1:0] r_sel;
  logic [LW-1:0] r_beats_left;
  logic          r_buf_full;
  logic [DW-1:0] r_buf_dat;
  logic          r_err;
  logic          r_rdat_valid;
  logic [DW-1:0] r_rdat;
  logic          r_rdat_last;

  logic          w_in_burst;
  logic          w_stb;
  logic          w_ack;
  logic          w_err;
  logic          w_last;
  logic          w_cmd_fire;
  logic          w_wdat_fire;
  logic [LW-1:0] w_beats_clamped;

  assign w_in_burst  = (r_state == S_BURST);
  // Write beats only strobe once their data sits in the buffer.
  assign w_stb       = w_in_burst & (r_we ? r_buf_full : 1'b1);
  // An error response always takes precedence over a simultaneous ack.
  assign w_err       = w_stb & wb_err_i;
  assign w_ack       = w_stb & wb_ack_i & ~wb_err_i;
  assign w_last      = (r_beats_left == LW'(1));
  assign w_cmd_fire  = cmd_valid_i & cmd_ready_o;
  assign w_wdat_fire = wdat_valid_i & wdat_ready_o;

  always_comb begin
    w_beats_clamped = cmd_len_i;
    if (cmd_len_i == '0) begin
      w_beats_clamped = LW'(1);
    end else if (cmd_len_i > LW'(MAXLEN)) begin
      w_beats_clamped = LW'(MAXLEN);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready_o  = 1'b0;
    wb_cyc_o     = 1'b0;
    wb_stb_o     = 1'b0;
    wb_cti_o     = 3'b000;
    wdat_ready_o = 1'b0;
    done_o       = 1'b0;
    done_err_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated so the handshake reads low for the whole time reset is held.
        cmd_ready_o = ~wb_rst_i;
        if (w_cmd_fire) begin
          w_state_next = S_BURST;
        end
      end
      S_BURST: begin
        wb_cyc_o     = 1'b1;
        wb_stb_o     = w_stb;
        wb_cti_o     = w_last ? 3'b111 : 3'b010;
        // Refill on the ack cycle keeps write beats back-to-back.
        wdat_ready_o = r_we & (~r_buf_full | (w_ack & ~w_last));
        if (w_err || (w_ack && w_last)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_o       = 1'b1;
        done_err_o   = r_err;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_adr        <= '0;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_beats_left <= '0;
      r_buf_full   <= 1'b0;
      r_buf_dat    <= '0;
      r_err        <= 1'b0;
    end else if (w_cmd_fire) begin
      r_adr        <= cmd_adr_i;
      r_we         <= cmd_we_i;
      r_sel        <= cmd_sel_i;
      r_beats_left <= w_beats_clamped;
      r_buf_full   <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_in_burst) begin
      if (w_ack) begin
        r_adr        <= r_adr + AW'(1);
        r_beats_left <= r_beats_left - LW'(1);
      end
      if (w_err) begin
        r_err      <= 1'b1;
        r_buf_full <= 1'b0;
      end else begin
        r_buf_full <= (r_buf_full & ~w_ack) | w_wdat_fire;
      end
      if (w_wdat_fire) begin
        r_buf_dat <= wdat_i;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rdat_valid <= 1'b0;
      r_rdat_last  <= 1'b0;
      r_rdat       <= '0;
    end else begin
      r_rdat_valid <= w_ack & ~r_we;
      r_rdat_last  <= w_ack & ~r_we & w_last;
      if (w_ack && !r_we) begin
        r_rdat <= wb_dat_i;
      end
    end
  end

  assign rdat_valid_o = r_rdat_valid;
  assign rdat_o       = r_rdat;
  assign rdat_last_o  = r_rdat_last;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_buf_dat;
  assign wb_sel_o     = r_sel;
  assign wb_we_o      = r_we;
  assign wb_bte_o     = 2'b00;

endmodule
